pipe_stage: RTL and testbench

//  Generic elastic pipeline register for the lc3b pipeline.
//  It replaces the fixed if_id/id_ex/ex_mem/mem_wb latches.
//  - Carries a WIDTH-bit stage bundle (control word, PC, operands) under a valid/ready handshake.
//  - Optional 2-entry skid buffer, so in_ready is registered and the stage sustains one beat per cycle.
//  - Synchronous flush for branch/trap squash.
//  - Saturating stall-cycle counter for performance analysis.

---
 rtl/pipe_stage.sv | 103 ++++++++++
 tb/tb_pipe_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register with optional skid entry,
// synchronous squash and a saturating stall-cycle counter.
module pipe_stage #(
  parameter int                 WIDTH         = 64,
  parameter int                 SKID          = 1,
  parameter logic [WIDTH-1:0]   RESET_PAYLOAD = '0,
  parameter int                 CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire, out_fire, stall;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

  // Without the skid entry, ready must look through to downstream.
  assign in_ready = (SKID != 0) ? rdy_q
                  : (!out_valid || out_ready);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && (SKID != 0)) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_PAYLOAD;
      skid_q  <= RESET_PAYLOAD;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboarded bench for pipe_stage: skid, no-skid and
// narrow-counter instances driven with directed vectors.
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: SKID=1, scoreboarded
  logic        fl0 = 0, iv0 = 0, ir0, ov0, or0 = 1;
  logic [15:0] id0 = 0, od0;
  logic [1:0]  occ0;
  logic [15:0] sc0;
  // u1: SKID=0
  logic        fl1 = 0, iv1 = 0, ir1, ov1, or1 = 0;
  logic [15:0] id1 = 0, od1;
  logic [1:0]  occ1;
  logic [15:0] sc1;
  // u2: CNT_W=4
  logic        fl2 = 0, iv2 = 0, ir2, ov2, or2 = 0;
  logic [15:0] id2 = 0, od2;
  logic [1:0]  occ2;
  logic [3:0]  sc2;

  pipe_stage #(.WIDTH(16), .SKID(1), .RESET_PAYLOAD(16'h0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(occ0), .stall_cnt(sc0));

  pipe_stage #(.WIDTH(16), .SKID(0), .RESET_PAYLOAD(16'h0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(occ1), .stall_cnt(sc1));

  pipe_stage #(.WIDTH(16), .SKID(1), .RESET_PAYLOAD(16'h0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .occupancy(occ2), .stall_cnt(sc2));

  int checks = 0;
  int passed = 0;
  logic [15:0] q[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every output handshake of u0 must match the queue head
  always @(negedge clk) begin
    if (!rst && ov0 && or0) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(od0), 64'hFFFF_FFFF);
      end else begin
        chk("beat", 64'(od0), 64'(q.pop_front()));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    nxt(); nxt();
    rst = 0;
    @(negedge clk);
    chk("rst_ov", 64'(ov0), 64'(0));
    chk("rst_occ", 64'(occ0), 64'(0));
    chk("rst_data", 64'(od0), 64'(0));
    chk("rst_cnt", 64'(sc0), 64'(0));
    chk("rst_ir", 64'(ir0), 64'(1));
    nxt();

    // Streaming, out_ready=1
    for (int k = 0; k < 8; k++) begin
      id0 = 16'(k + 1);
      iv0 = 1;
      q.push_back(16'(k + 1));
      @(negedge clk);
      if (k >= 1) begin
        chk("str_ov", 64'(ov0), 64'(1));
        chk("str_occ", 64'(occ0), 64'(1));
      end
      nxt();
    end
    iv0 = 0;
    nxt();
    @(negedge clk);
    chk("str_drain", 64'(occ0), 64'(0));
    nxt();

    // Backpressure into skid
    or0 = 0;
    iv0 = 1; id0 = 16'hA; q.push_back(16'hA);
    nxt();
    id0 = 16'hB; q.push_back(16'hB);
    nxt();
    iv0 = 0;
    @(negedge clk);
    chk("bp_occ", 64'(occ0), 64'(2));
    chk("bp_ir", 64'(ir0), 64'(0));
    chk("bp_hold", 64'(od0), 64'hA);
    repeat (3) @(posedge clk);
    #1;
    or0 = 1;
    nxt(); nxt();
    @(negedge clk);
    chk("bp_cnt", 64'(sc0), 64'(4));
    chk("bp_empty", 64'(occ0), 64'(0));
    nxt();

    // Flush while FULL with a beat offered
    or0 = 0;
    iv0 = 1; id0 = 16'hC;
    nxt();
    id0 = 16'hD;
    nxt();
    id0 = 16'hE; fl0 = 1;
    nxt();
    fl0 = 0; iv0 = 0; or0 = 1;
    @(negedge clk);
    chk("fl_ov", 64'(ov0), 64'(0));
    chk("fl_occ", 64'(occ0), 64'(0));
    chk("fl_ir", 64'(ir0), 64'(1));
    chk("fl_cnt", 64'(sc0), 64'(6));
    nxt();
    iv0 = 1; id0 = 16'hF; q.push_back(16'hF);
    nxt();
    iv0 = 0;
    nxt(); nxt();

    // SKID=0 backpressure
    iv1 = 1; id1 = 16'h11;
    @(negedge clk);
    chk("s0_ir_empty", 64'(ir1), 64'(1));
    nxt();
    id1 = 16'h22;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s0_ir", 64'(ir1), 64'(0));
      chk("s0_occ", 64'(occ1), 64'(1));
      chk("s0_hold", 64'(od1), 64'h11);
      nxt();
    end
    or1 = 1;
    @(negedge clk);
    chk("s0_ir_thru", 64'(ir1), 64'(1));
    nxt();
    iv1 = 0;
    @(negedge clk);
    chk("s0_data", 64'(od1), 64'h22);
    chk("s0_occ1", 64'(occ1), 64'(1));
    nxt();
    @(negedge clk);
    chk("s0_drain", 64'(occ1), 64'(0));
    nxt();

    // Counter saturation, CNT_W=4
    iv2 = 1; id2 = 16'h5A;
    nxt();
    iv2 = 0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("sat_14", 64'(sc2), 64'(14));
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sat_15", 64'(sc2), 64'(15));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 64'(sc2), 64'(15));
    nxt();

    // Reset asserted mid-transfer
    or0 = 1;
    iv0 = 1; id0 = 16'h77;
    nxt();
    id0 = 16'h88;
    #2;
    rst = 1;
    iv0 = 0;
    @(negedge clk);
    chk("mrst_ov", 64'(ov0), 64'(0));
    chk("mrst_occ", 64'(occ0), 64'(0));
    chk("mrst_data", 64'(od0), 64'(0));
    chk("mrst_cnt", 64'(sc0), 64'(0));
    chk("mrst_ir", 64'(ir0), 64'(1));
    nxt();
    rst = 0;
    nxt();

    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
